// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receive path.
//   spi_state_t   : frame FSM state (IDLE, ACTIVE)
//   SPI_CPOL/CPHA : SPI mode 0 (SCK idles low, sample on rising edge)
//   *_IDLE        : pin levels the input synchronizers reset to
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  // Synchronizer reset levels: CS deasserted, SCK at its mode-0 idle, MOSI low.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = SPI_CPOL;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Brings one asynchronous SPI pin into the clk domain through STAGES flops,
// follows it with a history flop and registers rise/fall pulses.
//   STAGES    : synchronizer depth (2..3)
//   RESET_VAL : level the chain and history flop take in reset
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous pin
//   level      : synchronized level, aligned with rise/fall
//   rise, fall : one-cycle pulses on detected edges
// Latency: a pin edge shows up on rise/fall STAGES+1 clk edges later.
// -----------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      hist <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~hist;
      fall <= ~sync[STAGES-1] & hist;
    end
  end

  // History flop is the level that lines up with the registered pulses.
  assign level = hist;

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 slave receiver, MSB first, oversampled by I_clk (>= 8x SCK).
// Optional transmit path enabled by defining SPI_SLAVE_RX_MISO_EN.
// Parameters:
//   DATA_W      : frame width in bits (>= 2)
//   SYNC_STAGES : synchronizer flops per SPI input (2..3)
// Ports:
//   I_clk, I_rst_n           : system clock, asynchronous active-low reset
//   I_spi_sck/cs/mosi        : asynchronous SPI pins (CS active-low)
//   O_spi_miso, O_spi_miso_oe: slave data out and its drive enable
//   I_tx_data, O_tx_load     : response word and its latch strobe
//   O_rx_data, O_rx_valid    : last received word and its update strobe
//   O_frame_err              : pulse when CS rises mid-word
//   O_busy                   : high while the frame is active
// O_rx_valid rises SYNC_STAGES+2 clk edges after the last SCK pin edge.
// -----------------------------------------------------------------------------
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_spi_sck,
  input  logic              I_spi_cs,
  input  logic              I_spi_mosi,
  output logic              O_spi_miso,
  output logic              O_spi_miso_oe,
  input  logic [DATA_W-1:0] I_tx_data,
  output logic              O_tx_load,
  output logic [DATA_W-1:0] O_rx_data,
  output logic              O_rx_valid,
  output logic              O_frame_err,
  output logic              O_busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sync_sck (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .din   (I_spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_sync_cs (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .din   (I_spi_cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .din   (I_spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_after;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] next_word;
  logic              last_bit;

  assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign next_word = {rx_shift[DATA_W-2:0], mosi_level};

  // Bit count after this cycle's SCK edge; lets a CS rise landing on the
  // final rising edge complete the word instead of flagging an error.
  always_comb begin
    cnt_after = bit_cnt;
    if (sck_rise) begin
      cnt_after = last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      O_rx_data   <= '0;
      O_rx_valid  <= 1'b0;
      O_frame_err <= 1'b0;
      O_busy      <= 1'b0;
    end else begin
      O_rx_valid  <= 1'b0;
      O_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            O_busy  <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (sck_rise) begin
            rx_shift <= next_word;
            bit_cnt  <= cnt_after;
            if (last_bit) begin
              O_rx_data  <= next_word;
              O_rx_valid <= 1'b1;
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            O_busy  <= 1'b0;
            bit_cnt <= '0;
            if (cnt_after != '0) begin
              O_frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_RX_MISO_EN
  logic [DATA_W-1:0] tx_shift;

  // A falling edge seen with bit_cnt at zero follows a completed word,
  // so it starts the next response word rather than shifting.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tx_shift      <= '0;
      O_spi_miso    <= 1'b0;
      O_spi_miso_oe <= 1'b0;
      O_tx_load     <= 1'b0;
    end else begin
      O_tx_load <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          tx_shift      <= I_tx_data;
          O_spi_miso    <= I_tx_data[DATA_W-1];
          O_spi_miso_oe <= 1'b1;
          O_tx_load     <= 1'b1;
        end
      end else if (cs_rise) begin
        O_spi_miso    <= 1'b0;
        O_spi_miso_oe <= 1'b0;
      end else if (sck_fall) begin
        if (bit_cnt == '0) begin
          tx_shift   <= I_tx_data;
          O_spi_miso <= I_tx_data[DATA_W-1];
          O_tx_load  <= 1'b1;
        end else begin
          tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
          O_spi_miso <= tx_shift[DATA_W-2];
        end
      end
    end
  end

  logic unused_sync;
  assign unused_sync = sck_level ^ cs_level ^ mosi_rise ^ mosi_fall;
`else
  assign O_spi_miso    = 1'b0;
  assign O_spi_miso_oe = 1'b0;
  assign O_tx_load     = 1'b0;

  logic unused_sync;
  assign unused_sync = sck_level ^ sck_fall ^ cs_level ^ mosi_rise ^ mosi_fall
                       ^ (^I_tx_data);
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

  localparam int  DW   = 8;
  localparam int  SS   = 2;
  localparam time HALF = 40;  // SCK half period: SCK = I_clk / 8

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          miso, miso_oe, tx_load, rx_valid, frame_err, busy;
  logic [DW-1:0] rx_data;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_spi_sck     (sck),
    .I_spi_cs      (cs),
    .I_spi_mosi    (mosi),
    .O_spi_miso    (miso),
    .O_spi_miso_oe (miso_oe),
    .I_tx_data     (tx_data),
    .O_tx_load     (tx_load),
    .O_rx_data     (rx_data),
    .O_rx_valid    (rx_valid),
    .O_frame_err   (frame_err),
    .O_busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int load_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] miso_word = '0;

  // Monitor: records every reported word and counts strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        obs_q.push_back(rx_data);
        rx_cnt++;
      end
      if (frame_err) err_cnt++;
      if (tx_load) load_cnt++;
    end
  end

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_counts();
    rx_cnt = 0;
    err_cnt = 0;
    load_cnt = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Master: n bits of b, MSB first; MISO sampled on each rising SCK.
  task automatic spi_bits(input logic [DW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[DW-1-i];
      #HALF;
      sck = 1'b1;
      miso_word = {miso_word[DW-2:0], miso};
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    align();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int n;
    logic [DW-1:0] e, o;
    clear_counts();
    align();
    exp_q.push_back(8'hA5);
    cs = 1'b0;
    #HALF;
    spi_bits(8'hA5, 7);
    mosi = 1'b1;
    #HALF;
    sck = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rx_valid && n < 20);
    checks++; if (n != SS + 2) begin errors++; $display("FAIL rx_latency got=%0d exp=%0d", n, SS + 2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_frame got=%b exp=1", busy); end
    #HALF;
    sck = 1'b0;
    #HALF;
    cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_cnt != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", rx_cnt); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data got=%h exp=a5", rx_data); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL single_frame_err got=%0d exp=0", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_frame got=%b exp=0", busy); end
`ifndef SPI_SLAVE_RX_MISO_EN
    checks++; if (load_cnt != 0) begin errors++; $display("FAIL tx_load_tied got=%0d exp=0", load_cnt); end
`endif
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_sb_size got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e, o, v;
    clear_counts();
    align();
    cs = 1'b0;
    #HALF;
    for (int i = 0; i < 256; i++) begin
      v = DW'(i);
      exp_q.push_back(v);
      spi_bits(v, DW);
    end
    #HALF;
    cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_cnt != 256) begin errors++; $display("FAIL b2b_count got=%0d exp=256", rx_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_sb_size got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_sb got=%h exp=%h", o, e); end
    end
  endtask

  // Runs after back-to-back, so the held word is 8'hFF.
  task automatic test_frame_err();
    clear_counts();
    align();
    cs = 1'b0;
    #HALF;
    spi_bits(8'h3C, 5);
    #HALF;
    cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL partial_frame_err got=%0d exp=1", err_cnt); end
    checks++; if (rx_cnt != 0) begin errors++; $display("FAIL partial_rx_valid got=%0d exp=0", rx_cnt); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL partial_rx_hold got=%h exp=ff", rx_data); end
  endtask

  task automatic test_cs_high_sck();
    int busy_seen;
    clear_counts();
    busy_seen = 0;
    align();
    for (int i = 0; i < 16; i++) begin
      mosi = i[1];
      #HALF;
      sck = ~sck;
      if (busy) busy_seen++;
    end
    repeat (10) @(posedge clk);
    #1;
    if (busy) busy_seen++;
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL cs_high_busy got=%0d exp=0", busy_seen); end
    checks++; if (rx_cnt != 0) begin errors++; $display("FAIL cs_high_rx got=%0d exp=0", rx_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL cs_high_err got=%0d exp=0", err_cnt); end
    checks++; if (load_cnt != 0) begin errors++; $display("FAIL cs_high_load got=%0d exp=0", load_cnt); end
  endtask

  // CS rises at the same pin instant as the final SCK rise.
  task automatic test_coincide();
    logic [DW-1:0] e, o;
    clear_counts();
    align();
    exp_q.push_back(8'h96);
    cs = 1'b0;
    #HALF;
    spi_bits(8'h96, 7);
    mosi = 1'b0;
    #HALF;
    sck = 1'b1;
    cs = 1'b1;
    #HALF;
    sck = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_cnt != 1) begin errors++; $display("FAIL coincide_count got=%0d exp=1", rx_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL coincide_err got=%0d exp=0", err_cnt); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL coincide_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [DW-1:0] e, o;
    clear_counts();
    align();
    cs = 1'b0;
    #HALF;
    spi_bits(8'hF0, 4);
    align();
    rst_n = 1'b0;
    #2;
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    cs = 1'b1;
    repeat (5) @(posedge clk);
    align();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_cnt + err_cnt != 0) begin errors++; $display("FAIL midrst_pulses got=%0d exp=0", rx_cnt + err_cnt); end
    align();
    exp_q.push_back(8'h81);
    cs = 1'b0;
    #HALF;
    spi_bits(8'h81, 8);
    #HALF;
    cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_cnt != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", rx_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL midrst_err got=%0d exp=0", err_cnt); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_sb got=%h exp=%h", o, e); end
    end
  endtask

`ifdef SPI_SLAVE_RX_MISO_EN
  // Frame ends with CS rising while SCK is still high, so no falling
  // edge after the second word starts a third response word.
  task automatic test_miso();
    clear_counts();
    align();
    tx_data = 8'hC3;
    miso_word = '0;
    cs = 1'b0;
    #HALF;
    #HALF;
    tx_data = 8'h5A;
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL miso_oe_active got=%b exp=1", miso_oe); end
    spi_bits(8'h11, 8);
    checks++; if (miso_word !== 8'hC3) begin errors++; $display("FAIL miso_word0 got=%h exp=c3", miso_word); end
    spi_bits(8'h22, 7);
    mosi = 1'b0;
    #HALF;
    sck = 1'b1;
    miso_word = {miso_word[DW-2:0], miso};
    #HALF;
    cs = 1'b1;
    #HALF;
    sck = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (miso_word !== 8'h5A) begin errors++; $display("FAIL miso_word1 got=%h exp=5a", miso_word); end
    checks++; if (load_cnt != 2) begin errors++; $display("FAIL tx_load_count got=%0d exp=2", load_cnt); end
    checks++; if (rx_cnt != 2) begin errors++; $display("FAIL miso_rx_count got=%0d exp=2", rx_cnt); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL miso_oe_idle got=%b exp=0", miso_oe); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_cs_high_sck();
    test_coincide();
    test_reset_mid_word();
`ifdef SPI_SLAVE_RX_MISO_EN
    test_miso();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
